// File: rtl/udma_filter_tx_operand_fetch.sv
// Operand-fetch engine of the uDMA filter: walks L2 in LINEAR/SLIDING/CIRCULAR/2D order over a TX channel
// and streams the returned words. Define UDMA_FILTER_TX_ALIGN_EN to right-align byte/half reads.
module udma_filter_tx_operand_fetch #(
  parameter int DATA_WIDTH     = 32,
  parameter int L2_AWIDTH_NOAL = 15,
  parameter int BUFFER_DEPTH   = 4,
  parameter int TRANS_SIZE     = 16
) (
  input  logic                      clk_i,
  input  logic                      resetn_i,
  output logic                      tx_ch_req_o,
  output logic [L2_AWIDTH_NOAL-1:0] tx_ch_addr_o,
  output logic [1:0]                tx_ch_datasize_o,
  input  logic                      tx_ch_gnt_i,
  input  logic                      tx_ch_valid_i,
  input  logic [DATA_WIDTH-1:0]     tx_ch_data_i,
  output logic                      tx_ch_ready_o,
  input  logic                      cmd_start_i,
  output logic                      cmd_done_o,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_start_addr_i,
  input  logic [1:0]                cfg_datasize_i,
  input  logic [1:0]                cfg_mode_i,
  input  logic [TRANS_SIZE-1:0]     cfg_len0_i,
  input  logic [TRANS_SIZE-1:0]     cfg_len1_i,
  input  logic [TRANS_SIZE-1:0]     cfg_len2_i,
  output logic [DATA_WIDTH-1:0]     stream_data_o,
  output logic                      stream_valid_o,
  output logic                      stream_eof_o,
  input  logic                      stream_ready_i
);
  localparam int AW = L2_AWIDTH_NOAL;
  localparam int PW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(BUFFER_DEPTH);
  localparam logic [1:0] MODE_LIN = 2'd0, MODE_SLD = 2'd1, MODE_2D = 2'd3;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d, dsize_q, dsize_d;
  logic [AW-1:0]         addr_q, addr_d, base_q, base_d;
  logic [TRANS_SIZE-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [CW-1:0]         credits_q, credits_d, out_q, out_d, last_out_q, last_out_d, fill_q, fill_d;
  logic                  last_pend_q, last_pend_d, done_q, done_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_data_q [BUFFER_DEPTH];
  logic                  fifo_eof_q  [BUFFER_DEPTH];

  logic [AW-1:0]         inc, stride;
  logic                  req, grant, push, pop, push_eof, row_end, last_req;
  logic [DATA_WIDTH-1:0] push_data;

  always_comb begin
    case (dsize_q)
      2'b00:   inc = AW'(1);
      2'b01:   inc = AW'(2);
      2'b10:   inc = AW'(4);
      default: inc = '0;
    endcase
  end

  assign stride   = AW'(cfg_len1_i);
  assign row_end  = (cnt0_q == cfg_len0_i);
  assign last_req = row_end && ((mode_q == MODE_LIN) ||
                    (cnt1_q == ((mode_q == MODE_2D) ? cfg_len2_i : cfg_len1_i)));
  // Credits cover both in-flight reads and buffered beats, so a return always finds a free slot.
  assign req   = (state_q == FETCH) && (credits_q < DEPTH);
  assign grant = req && tx_ch_gnt_i;
  // Data with nothing outstanding is stale (e.g. from before a reset) and is dropped.
  assign push  = tx_ch_valid_i && (out_q != '0);
  assign pop   = stream_valid_o && stream_ready_i;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dsize_d = dsize_q;
    addr_d  = addr_q;
    base_d  = base_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    done_d  = pop && stream_eof_o;
    case (state_q)
      IDLE: begin
        if (cmd_start_i) begin
          state_d = FETCH;
          mode_d  = cfg_mode_i;
          dsize_d = cfg_datasize_i;
          addr_d  = cfg_start_addr_i;
          base_d  = cfg_start_addr_i;
          cnt0_d  = '0;
          cnt1_d  = '0;
        end
      end
      FETCH: begin
        if (grant) begin
          if (last_req) begin
            state_d = DRAIN;
          end else if (!row_end) begin
            cnt0_d = cnt0_q + TRANS_SIZE'(1);
            addr_d = addr_q + inc;
          end else begin
            cnt0_d = '0;
            cnt1_d = cnt1_q + TRANS_SIZE'(1);
            // base is the window start (SLIDING), row start (2D) or fixed start (CIRCULAR)
            case (mode_q)
              MODE_SLD: begin base_d = base_q + inc;    addr_d = base_q + inc;    end
              MODE_2D:  begin base_d = base_q + stride; addr_d = base_q + stride; end
              default:  addr_d = base_q;
            endcase
          end
        end
      end
      DRAIN: if (pop && stream_eof_o) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The eof beat is located by counting returns still ahead of the last request.
  always_comb begin
    credits_d   = credits_q + CW'(grant) - CW'(pop);
    out_d       = out_q + CW'(grant) - CW'(push);
    fill_d      = fill_q + CW'(push) - CW'(pop);
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    last_pend_d = last_pend_q;
    last_out_d  = last_out_q;
    push_eof    = 1'b0;
    if (push && last_pend_q) begin
      if (last_out_q == CW'(1)) begin
        push_eof    = 1'b1;
        last_pend_d = 1'b0;
      end else begin
        last_out_d = last_out_q - CW'(1);
      end
    end
    if (grant && last_req) begin
      last_pend_d = 1'b1;
      last_out_d  = out_q + CW'(1) - CW'(push);
    end
  end

`ifdef UDMA_FILTER_TX_ALIGN_EN
  logic [1:0]            tag_q [BUFFER_DEPTH];
  logic [PW-1:0]         tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    tag_wr_d = tag_wr_q + PW'(grant);
    tag_rd_d = tag_rd_q + PW'(push);
    shifted  = tx_ch_data_i >> {tag_q[tag_rd_q], 3'b000};
    case (dsize_q)
      2'b00:   push_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      2'b01:   push_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: push_data = tx_ch_data_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      tag_wr_q <= '0;
      tag_rd_q <= '0;
    end else begin
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant) tag_q[tag_wr_q] <= addr_q[1:0];
  end
`else
  assign push_data = tx_ch_data_i;
`endif

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      dsize_q     <= '0;
      addr_q      <= '0;
      base_q      <= '0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
      credits_q   <= '0;
      out_q       <= '0;
      last_out_q  <= '0;
      fill_q      <= '0;
      last_pend_q <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      dsize_q     <= dsize_d;
      addr_q      <= addr_d;
      base_q      <= base_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
      credits_q   <= credits_d;
      out_q       <= out_d;
      last_out_q  <= last_out_d;
      fill_q      <= fill_d;
      last_pend_q <= last_pend_d;
      done_q      <= done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_eof_q[wr_ptr_q]  <= push_eof;
    end
  end

  assign tx_ch_req_o      = req;
  assign tx_ch_addr_o     = addr_q;
  assign tx_ch_datasize_o = cfg_datasize_i;
  assign tx_ch_ready_o    = 1'b1;
  assign cmd_done_o       = done_q;
  assign stream_valid_o   = (fill_q != '0);
  assign stream_data_o    = fifo_data_q[rd_ptr_q];
  assign stream_eof_o     = stream_valid_o && fifo_eof_q[rd_ptr_q];

`ifndef SYNTHESIS
  a_data_has_credit: assert property (@(posedge clk_i) disable iff (!resetn_i)
    (tx_ch_valid_i && (state_q != IDLE)) |-> (credits_q != '0));
`endif
endmodule

// File: tb/tb_udma_filter_tx_operand_fetch.sv
// Directed bench for udma_filter_tx_operand_fetch: table of address-pattern vectors plus
// hand-written stall, backpressure and reset sequences against an in-order L2 responder.
module tb_udma_filter_tx_operand_fetch;
  localparam int AW = 15;
  localparam int TS = 16;
`ifdef UDMA_FILTER_TX_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          resetn_i;
  logic          tx_ch_req_o, tx_ch_gnt_i, tx_ch_valid_i, tx_ch_ready_o;
  logic [AW-1:0] tx_ch_addr_o, cfg_start_addr_i;
  logic [1:0]    tx_ch_datasize_o, cfg_datasize_i, cfg_mode_i;
  logic [31:0]   tx_ch_data_i, stream_data_o;
  logic          cmd_start_i, cmd_done_o, stream_valid_o, stream_eof_o, stream_ready_i;
  logic [TS-1:0] cfg_len0_i, cfg_len1_i, cfg_len2_i;

  always #5 clk_i = ~clk_i;

  udma_filter_tx_operand_fetch dut (
    .clk_i(clk_i), .resetn_i(resetn_i),
    .tx_ch_req_o(tx_ch_req_o), .tx_ch_addr_o(tx_ch_addr_o), .tx_ch_datasize_o(tx_ch_datasize_o),
    .tx_ch_gnt_i(tx_ch_gnt_i), .tx_ch_valid_i(tx_ch_valid_i), .tx_ch_data_i(tx_ch_data_i),
    .tx_ch_ready_o(tx_ch_ready_o), .cmd_start_i(cmd_start_i), .cmd_done_o(cmd_done_o),
    .cfg_start_addr_i(cfg_start_addr_i), .cfg_datasize_i(cfg_datasize_i), .cfg_mode_i(cfg_mode_i),
    .cfg_len0_i(cfg_len0_i), .cfg_len1_i(cfg_len1_i), .cfg_len2_i(cfg_len2_i),
    .stream_data_o(stream_data_o), .stream_valid_o(stream_valid_o), .stream_eof_o(stream_eof_o),
    .stream_ready_i(stream_ready_i)
  );

  typedef struct packed {
    logic [1:0]          mode;
    logic [1:0]          ds;
    logic [AW-1:0]       addr;
    logic [TS-1:0]       l0, l1, l2;
    logic [3:0]          n;
    logic [0:7][AW-1:0]  exp;
  } vec_t;

  vec_t          tbl [7];
  vec_t          vs;
  int            n_vec = 0, n_bad = 0, cyc = 0;
  logic [AW-1:0] gq[$], pend[$];
  logic [31:0]   bd[$];
  bit            be[$];
  int            bc[$], dc[$];
  bit            use_fixed = 1'b0;
  logic [31:0]   fixed_data = '0;

  function automatic logic [31:0] mem_data(input logic [AW-1:0] a);
    return use_fixed ? fixed_data : (32'hA500_0000 | 32'(a));
  endfunction

  function automatic logic [31:0] exp_beat(input logic [AW-1:0] a, input logic [1:0] ds);
    logic [31:0] d;
    d = mem_data(a);
    if (ALIGN && (ds == 2'b00 || ds == 2'b01)) begin
      d = d >> (8 * a[1:0]);
      d = (ds == 2'b00) ? {24'h0, d[7:0]} : {16'h0, d[15:0]};
    end
    return d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge after the caller has set inputs for the coming posedge.
  task automatic cycle();
    tx_ch_valid_i = 1'b0;
    if (pend.size() > 0) begin
      tx_ch_valid_i = 1'b1;
      tx_ch_data_i  = mem_data(pend.pop_front());
    end
    if (tx_ch_req_o && tx_ch_gnt_i) begin
      gq.push_back(tx_ch_addr_o);
      pend.push_back(tx_ch_addr_o);
    end
    if (stream_valid_o && stream_ready_i) begin
      bd.push_back(stream_data_o);
      be.push_back(stream_eof_o);
      bc.push_back(cyc);
    end
    if (cmd_done_o) dc.push_back(cyc);
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic clear();
    gq.delete(); bd.delete(); be.delete(); bc.delete(); dc.delete();
  endtask

  task automatic start(input vec_t v);
    clear();
    cfg_mode_i = v.mode; cfg_datasize_i = v.ds; cfg_start_addr_i = v.addr;
    cfg_len0_i = v.l0; cfg_len1_i = v.l1; cfg_len2_i = v.l2;
    cmd_start_i = 1'b1;
    cycle();
    cmd_start_i = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 400 && dc.size() == 0; k++) cycle();
    repeat (3) cycle();
  endtask

  task automatic check_result(input vec_t v, input int id);
    int n;
    n = int'(v.n);
    check($sformatf("v%0d_ngrant", id), 32'(gq.size()), 32'(n));
    for (int i = 0; i < n; i++)
      check($sformatf("v%0d_addr%0d", id, i), (i < gq.size()) ? 32'(gq[i]) : 32'hFFFF_FFFF, 32'(v.exp[i]));
    check($sformatf("v%0d_nbeat", id), 32'(bd.size()), 32'(n));
    for (int i = 0; i < n && i < bd.size(); i++) begin
      check($sformatf("v%0d_data%0d", id, i), bd[i], exp_beat(v.exp[i], v.ds));
      check($sformatf("v%0d_eof%0d", id, i), 32'(be[i]), 32'(i == n - 1));
    end
    check($sformatf("v%0d_ndone", id), 32'(dc.size()), 32'd1);
    if (dc.size() > 0 && bc.size() > 0)
      check($sformatf("v%0d_done_lat", id), 32'(dc[0] - bc[bc.size() - 1]), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    start(v);
    wait_done();
    check_result(v, id);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn_i = 1'b0; tx_ch_gnt_i = 1'b1; tx_ch_valid_i = 1'b0; tx_ch_data_i = '0;
    cmd_start_i = 1'b0; cfg_start_addr_i = '0; cfg_datasize_i = 2'b10; cfg_mode_i = '0;
    cfg_len0_i = '0; cfg_len1_i = '0; cfg_len2_i = '0; stream_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    resetn_i = 1'b1;
    check("rst_req", 32'(tx_ch_req_o), 32'd0);
    check("rst_valid", 32'(stream_valid_o), 32'd0);
    check("rst_eof", 32'(stream_eof_o), 32'd0);
    check("rst_done", 32'(cmd_done_o), 32'd0);
    check("rst_addr", 32'(tx_ch_addr_o), 32'd0);
    check("ready_tie", 32'(tx_ch_ready_o), 32'd1);

    //          mode  ds     addr      len0    len1     len2   n     expected addresses
    tbl[0] = '{2'd0, 2'd1, 15'h0100, 16'd3, 16'd0,   16'd0, 4'd4,
               {15'h100, 15'h102, 15'h104, 15'h106, 15'h0, 15'h0, 15'h0, 15'h0}};
    tbl[1] = '{2'd1, 2'd0, 15'h0010, 16'd2, 16'd1,   16'd0, 4'd6,
               {15'h10, 15'h11, 15'h12, 15'h11, 15'h12, 15'h13, 15'h0, 15'h0}};
    tbl[2] = '{2'd3, 2'd2, 15'h0000, 16'd1, 16'h20,  16'd2, 4'd6,
               {15'h0, 15'h4, 15'h20, 15'h24, 15'h40, 15'h44, 15'h0, 15'h0}};
    tbl[3] = '{2'd2, 2'd2, 15'h0008, 16'd1, 16'd2,   16'd0, 4'd6,
               {15'h8, 15'hC, 15'h8, 15'hC, 15'h8, 15'hC, 15'h0, 15'h0}};
    tbl[4] = '{2'd0, 2'd0, 15'h7FFE, 16'd3, 16'd0,   16'd0, 4'd4,
               {15'h7FFE, 15'h7FFF, 15'h0, 15'h1, 15'h0, 15'h0, 15'h0, 15'h0}};
    tbl[5] = '{2'd0, 2'd3, 15'h0040, 16'd2, 16'd0,   16'd0, 4'd3,
               {15'h40, 15'h40, 15'h40, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0}};
    tbl[6] = '{2'd0, 2'd2, 15'h0200, 16'd0, 16'd0,   16'd0, 4'd1,
               {15'h200, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0}};

    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    // Backpressure: with the consumer stalled only BUFFER_DEPTH reads may be granted.
    stream_ready_i = 1'b0;
    start(tbl[3]);
    repeat (15) cycle();
    check("bp_ngrant", 32'(gq.size()), 32'd4);
    check("bp_req_low", 32'(tx_ch_req_o), 32'd0);
    check("bp_valid", 32'(stream_valid_o), 32'd1);
    check("bp_head", stream_data_o, 32'hA500_0008);
    stream_ready_i = 1'b1;
    wait_done();
    check_result(tbl[3], 10);

    // Grant withheld mid-run; a start pulse while busy must be ignored.
    vs = '{2'd0, 2'd2, 15'h0300, 16'd5, 16'd0, 16'd0, 4'd6,
           {15'h300, 15'h304, 15'h308, 15'h30C, 15'h310, 15'h314, 15'h0, 15'h0}};
    start(vs);
    for (int k = 0; k < 50 && gq.size() < 2; k++) cycle();
    tx_ch_gnt_i = 1'b0;
    cfg_start_addr_i = 15'h0700;
    cfg_mode_i = 2'd3;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall_req%0d", k), 32'(tx_ch_req_o), 32'd1);
      check($sformatf("stall_addr%0d", k), 32'(tx_ch_addr_o), 32'h308);
      cmd_start_i = (k == 1);
      cycle();
    end
    cmd_start_i = 1'b0;
    tx_ch_gnt_i = 1'b1;
    wait_done();
    check_result(vs, 11);

    // Reset in the middle of FETCH: abort, no done, late read data discarded.
    stream_ready_i = 1'b0;
    vs = '{2'd0, 2'd2, 15'h0500, 16'd7, 16'd0, 16'd0, 4'd8,
           {15'h500, 15'h504, 15'h508, 15'h50C, 15'h510, 15'h514, 15'h518, 15'h51C}};
    start(vs);
    repeat (3) cycle();
    clear();
    resetn_i = 1'b0;
    #1;
    check("mid_rst_req", 32'(tx_ch_req_o), 32'd0);
    check("mid_rst_valid", 32'(stream_valid_o), 32'd0);
    check("mid_rst_eof", 32'(stream_eof_o), 32'd0);
    check("mid_rst_done", 32'(cmd_done_o), 32'd0);
    check("mid_rst_addr", 32'(tx_ch_addr_o), 32'd0);
    cycle();
    cycle();
    resetn_i = 1'b1;
    stream_ready_i = 1'b1;
    repeat (8) cycle();
    check("post_rst_beats", 32'(bd.size()), 32'd0);
    check("post_rst_done", 32'(dc.size()), 32'd0);
    check("post_rst_req", 32'(tx_ch_req_o), 32'd0);
    pend.delete();
    run_vec(tbl[0], 12);

`ifdef UDMA_FILTER_TX_ALIGN_EN
    use_fixed = 1'b1;
    fixed_data = 32'hAABB_CCDD;
    vs = '{2'd0, 2'd0, 15'h0101, 16'd0, 16'd0, 16'd0, 4'd1,
           {15'h101, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0}};
    start(vs);
    wait_done();
    check("align_byte", (bd.size() > 0) ? bd[0] : 32'hFFFF_FFFF, 32'h0000_00CC);
    use_fixed = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
